// File: rtl/trivium_stream_gen.sv
// Word-parallel Trivium keystream generator: W rounds per clock, internal key/IV
// warm-up, and keystream words delivered over a valid/ready handshake.
module trivium_stream_gen #(
    parameter int unsigned W           = 8,
    parameter int unsigned INIT_ROUNDS = 1152
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic [79:0]  key_i,
    input  logic [79:0]  iv_i,
    output logic         busy_o,
    output logic         ks_valid_o,
    input  logic         ks_ready_i,
    output logic [W-1:0] ks_data_o
);

    localparam int unsigned CntW = $clog2(INIT_ROUNDS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(INIT_ROUNDS - W);
    localparam logic [CntW-1:0] CntStep = CntW'(W);

    typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;

    state_e          state_q, state_d;
    logic [287:0]    s_q, s_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [287:0]    adv_state;
    logic [287:0]    load_state;
    logic [W-1:0]    z_word;

    // Bit i of the vector holds Trivium register s(i+1); returns {z, next_state}.
    function automatic logic [288:0] trivium_round(input logic [287:0] s);
        logic t1, t2, t3, z;
        t1 = s[65] ^ s[92];
        t2 = s[161] ^ s[176];
        t3 = s[242] ^ s[287];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[90] & s[91]) ^ s[170];
        t2 = t2 ^ (s[174] & s[175]) ^ s[263];
        t3 = t3 ^ (s[285] & s[286]) ^ s[68];
        return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
    endfunction

    always_comb begin
        adv_state = s_q;
        z_word    = '0;
        for (int k = 0; k < W; k++) begin
            {z_word[k], adv_state} = trivium_round(adv_state);
        end
    end

    assign load_state = {3'b111, 108'b0, 4'b0, iv_i, 13'b0, key_i};

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            s_d     = load_state;
            cnt_d   = '0;
            state_d = StInit;
        end else if (stop_i) begin
            // A word handed over on the stop edge is still consumed.
            if (state_q == StRun && ks_ready_i) begin
                s_d = adv_state;
            end
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StInit: begin
                    s_d = adv_state;
                    if (cnt_q == LastCnt) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q + CntStep;
                    end
                end
                StRun: begin
                    if (ks_ready_i) begin
                        s_d = adv_state;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            cnt_q   <= '0;
        end else if (enable_i) begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o     = (state_q == StInit);
    assign ks_valid_o = (state_q == StRun);
    assign ks_data_o  = (state_q == StRun) ? z_word : '0;

endmodule
